mdm_unit: RTL and testbench



---
 rtl/mdm_unit.sv | 159 +++++++++++++++
 tb/tb_mdm_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdm_unit.sv
// rtl/mdm_unit.sv - multi-cycle multiply/divide unit owning HI/LO (madd family via MDM_MADD_EN)
module mdm_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  MDMOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDM_RD,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

`ifdef MDM_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] hi_n, lo_n;
    logic        skip_wr;

    logic        busy_reg;
    logic        is_mul, is_div, is_acc, long_op;
    logic        accept, mt_write;

    assign busy_reg = (state == S_RUN);
    assign is_mul   = (MDMOp == OP_MULT) || (MDMOp == OP_MULTU);
    assign is_div   = (MDMOp == OP_DIV)  || (MDMOp == OP_DIVU);
    assign is_acc   = MADD_EN && (MDMOp >= OP_MADD) && (MDMOp <= OP_MSUBU);
    assign long_op  = is_mul || is_div || is_acc;
    assign accept   = Start && !Req && !busy_reg && long_op;
    assign mt_write = !Req && !busy_reg && ((MDMOp == OP_MTHI) || (MDMOp == OP_MTLO));

    // Low 64 bits of a 64x64 product of the extended operands equal the 32x32 result
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, prod, acc_res;

    assign mul_signed = (MDMOp == OP_MULT) || (MDMOp == OP_MADD) || (MDMOp == OP_MSUB);
    assign a_ext      = mul_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign b_ext      = mul_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign prod       = a_ext * b_ext;
    assign acc_res    = ((MDMOp == OP_MADD) || (MDMOp == OP_MADDU)) ? ({HI, LO} + prod)
                                                                    : ({HI, LO} - prod);

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    logic        div_signed, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;

    assign div_signed = (MDMOp == OP_DIV);
    assign a_neg      = div_signed && A[31];
    assign b_neg      = div_signed && B[31];
    assign a_mag      = a_neg ? (~A + 32'd1) : A;
    assign b_mag      = b_neg ? (~B + 32'd1) : B;
    assign div_zero   = (B == 32'd0);
    assign b_safe     = div_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign q_res      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_res      = a_neg ? (~r_mag + 32'd1) : r_mag;

    logic [31:0] res_hi, res_lo;
    logic [3:0]  res_cnt;

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_cnt = 4'(MULT_CYCLES);
        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (is_div) begin
            res_hi  = r_res;
            res_lo  = q_res;
            res_cnt = 4'(DIV_CYCLES);
        end else if (is_acc) begin
            res_hi = acc_res[63:32];
            res_lo = acc_res[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_RUN;
            S_RUN:  if (cnt == 4'd1) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = !reset && ((Start && !Req && long_op) || busy_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI      <= 32'd0;
            LO      <= 32'd0;
            hi_n    <= 32'd0;
            lo_n    <= 32'd0;
            cnt     <= 4'd0;
            skip_wr <= 1'b0;
        end else if (accept) begin
            hi_n    <= res_hi;
            lo_n    <= res_lo;
            cnt     <= res_cnt;
            skip_wr <= is_div && div_zero;
        end else if (busy_reg) begin
            if (cnt == 4'd1) begin
                cnt <= 4'd0;
                if (!skip_wr) begin
                    HI <= hi_n;
                    LO <= lo_n;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (mt_write) begin
            if (MDMOp == OP_MTHI) HI <= A;
            else                  LO <= A;
        end
    end

    always_comb begin
        MDM_RD = 32'd0;
        if (!reset) begin
            if (MDMOp == OP_MFHI)      MDM_RD = HI;
            else if (MDMOp == OP_MFLO) MDM_RD = LO;
        end
    end

endmodule

// File: tb/tb_mdm_unit.sv
// tb/tb_mdm_unit.sv - directed self-checking bench for mdm_unit
module tb_mdm_unit;

    logic        clk, reset, Req, Start;
    logic [3:0]  MDMOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] MDM_RD, HI, LO;

    int vecs = 0;
    int errs = 0;
    int n, m;

    mdm_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Req(Req), .Start(Start), .MDMOp(MDMOp),
        .A(A), .B(B), .Busy(Busy), .MDM_RD(MDM_RD), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int cnt_o);
        cnt_o = 0;
        for (int k = 0; k < 40; k++) begin
            if (!Busy) break;
            cnt_o++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cnt_o);
        int w;
        Start = 1'b1; MDMOp = op; A = a; B = b;
        #1;
        cnt_o = Busy ? 1 : 0;
        @(posedge clk); #1;
        Start = 1'b0; MDMOp = 4'd0;
        wait_idle(w);
        cnt_o += w;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        Start = 1'b0; MDMOp = op; A = a;
        #1;
        chk("mt_busy", {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        MDMOp = 4'd0;
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string tag);
        MDMOp = op;
        #1;
        chk(tag, MDM_RD, exp);
        MDMOp = 4'd0;
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; Start = 1'b1; MDMOp = 4'd7; A = 32'd5; B = 32'd6;
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_rd", MDM_RD, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; Start = 1'b0; MDMOp = 4'd0;

        // mult -2 x 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_busy_cycles", n, 32'd6);
        rd(4'd7, 32'hFFFF_FFFF, "mult_mfhi");
        rd(4'd8, 32'hFFFF_FFFA, "mult_mflo");

        // div -7 / 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_busy_cycles", n, 32'd11);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        // div overflow case
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'h0000_0000);

        // mtlo / mthi then divide by zero
        mt(4'd6, 32'h0000_1234);
        rd(4'd8, 32'h0000_1234, "mtlo_rd");
        mt(4'd5, 32'hCAFE_F00D);
        rd(4'd7, 32'hCAFE_F00D, "mthi_rd");
        run_op(4'd4, 32'd7, 32'd0, n);
        chk("div0_busy_cycles", n, 32'd11);
        chk("div0_lo", LO, 32'h0000_1234);
        chk("div0_hi", HI, 32'hCAFE_F00D);

        // reset in the middle of a div
        Start = 1'b1; MDMOp = 4'd3; A = 32'd100; B = 32'd7;
        #1;
        @(posedge clk); #1;
        Start = 1'b0; MDMOp = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; MDMOp = 4'd8;
        #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_rd", MDM_RD, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MDMOp = 4'd0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
        end
        chk("midrst_busy_after", {31'd0, Busy}, 32'd0);
        chk("midrst_lo_after", LO, 32'd0);
        run_op(4'd1, 32'd6, 32'd7, n);
        chk("postrst_busy_cycles", n, 32'd6);
        chk("postrst_lo", LO, 32'd42);
        chk("postrst_hi", HI, 32'd0);

        // Start suppressed by Req
        Start = 1'b1; Req = 1'b1; MDMOp = 4'd2; A = 32'd5; B = 32'd5;
        #1;
        chk("req_busy", {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        chk("req_busy_next", {31'd0, Busy}, 32'd0);
        Start = 1'b0; Req = 1'b0; MDMOp = 4'd0;
        chk("req_lo", LO, 32'd42);

        // Req during RUN does not cancel
        Start = 1'b1; MDMOp = 4'd2; A = 32'hFFFF_FFFF; B = 32'd2;
        #1;
        n = Busy ? 1 : 0;
        @(posedge clk); #1;
        Start = 1'b0; MDMOp = 4'd0; Req = 1'b1;
        wait_idle(m);
        Req = 1'b0;
        chk("reqrun_busy_cycles", n + m, 32'd6);
        chk("reqrun_hi", HI, 32'd1);
        chk("reqrun_lo", LO, 32'hFFFF_FFFE);

        // Start and mthi during RUN are ignored
        Start = 1'b1; MDMOp = 4'd1; A = 32'd3; B = 32'd4;
        #1;
        n = Busy ? 1 : 0;
        @(posedge clk); #1;
        Start = 1'b1; MDMOp = 4'd5; A = 32'hDEAD_BEEF; B = 32'd9;
        wait_idle(m);
        Start = 1'b0; MDMOp = 4'd0;
        chk("ignore_busy_cycles", n + m, 32'd6);
        chk("ignore_hi", HI, 32'd0);
        chk("ignore_lo", LO, 32'd12);

        // madd family
        mt(4'd5, 32'd0);
        mt(4'd6, 32'hFFFF_FFFF);
        run_op(4'd10, 32'd1, 32'd1, n);
`ifdef MDM_MADD_EN
        chk("maddu_busy_cycles", n, 32'd6);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
`else
        chk("maddu_busy_cycles", n, 32'd0);
        chk("maddu_hi", HI, 32'd0);
        chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif
        run_op(4'd11, 32'd2, 32'd3, n);
`ifdef MDM_MADD_EN
        chk("msub_hi", HI, 32'd0);
        chk("msub_lo", LO, 32'hFFFF_FFFA);
`else
        chk("msub_hi", HI, 32'd0);
        chk("msub_lo", LO, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
